// File: rtl/tiny_decimator_pkg.sv
// Shared types and helpers for the tiny_decimator block.
package tiny_decimator_pkg;

  typedef enum logic [0:0] {
    SM_IDLE = 1'b0,
    SM_RUN  = 1'b1
  } state_t;

  // Map a requested factor onto the legal range 1..max_decim.
  function automatic int unsigned clamp_decim(input int unsigned factor,
                                              input int unsigned max_decim);
    if (factor == 0) return 1;
    if (factor > max_decim) return max_decim;
    return factor;
  endfunction

endpackage

// File: rtl/tiny_decimator_if.sv
// Sample stream bus for tiny_decimator: input handshake, output handshake and FIFO level.
interface tiny_decimator_if #(
  parameter int G_DATA_WIDTH = 16,
  parameter int G_FIFO_DEPTH = 4
);
  localparam int LW = $clog2(G_FIFO_DEPTH) + 1;

  logic [G_DATA_WIDTH-1:0] din;
  logic                    din_valid;
  logic                    din_ready;
  logic [G_DATA_WIDTH-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [LW-1:0]           fifo_level;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, fifo_level
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, fifo_level
  );

endinterface

// File: rtl/tiny_decimator_fifo.sv
// Show-ahead FIFO holding kept samples; head, empty, full and level come straight from registers.
module tiny_decimator_fifo #(
  parameter int G_DATA_WIDTH = 16,
  parameter int G_DEPTH      = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [G_DATA_WIDTH-1:0]         wr_value,
  input  logic                            wr_valid,
  input  logic                            rd_accept,
  input  logic                            flush,
  output logic [G_DATA_WIDTH-1:0]         head_value,
  output logic                            empty,
  output logic                            full,
  output logic [$clog2(G_DEPTH):0]        level
);
  localparam int PW = $clog2(G_DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]           level_q, level_d;
  logic [G_DATA_WIDTH-1:0] mem_q [G_DEPTH];
  logic                    wr_en;
  logic                    rd_en;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(G_DEPTH));
  assign wr_en = wr_valid & ~full & ~flush;
  assign rd_en = rd_accept & ~empty & ~flush;

  // Masking keeps dout at zero whenever nothing is queued.
  assign head_value = empty ? '0 : mem_q[rd_ptr_q];
  assign level      = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  for (genvar gi = 0; gi < G_DEPTH; gi++) begin : g_entry
    logic [G_DATA_WIDTH-1:0] entry_d;

    always_comb begin
      entry_d = mem_q[gi];
      if (wr_en && (wr_ptr_q == PW'(gi))) entry_d = wr_value;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mem_q[gi] <= '0;
      else          mem_q[gi] <= entry_d;
    end
  end

endmodule

// File: rtl/tiny_decimator.sv
// Integer-factor decimator: keeps sample 0 of every group of D accepted samples into a small FIFO.
// Optional drop_count statistics port is enabled with `define TINY_DECIMATOR_STATS_EN.
module tiny_decimator
  import tiny_decimator_pkg::*;
#(
  parameter int G_DATA_WIDTH = 16,
  parameter int G_MAX_DECIM  = 16,
  parameter int G_FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [$clog2(G_MAX_DECIM):0] decim_factor,
`ifdef TINY_DECIMATOR_STATS_EN
  output logic [31:0]                drop_count,
`endif
  tiny_decimator_if.slave            bus
);
  localparam int CW = $clog2(G_MAX_DECIM) + 1;

  state_t        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [CW-1:0] d_active_q, d_active_d;
  logic [CW-1:0] factor_clamped;
  logic          din_ready_int;
  logic          accept;
  logic          keep;
  logic          flush;
  logic          fifo_empty;
  logic          fifo_full;

  assign factor_clamped = CW'(clamp_decim(32'(decim_factor), G_MAX_DECIM));

  // Non-zero phases are always accepted, so discards never stall the upstream FIR.
  assign din_ready_int = (state_q == SM_RUN) && ((phase_q != '0) || !fifo_full);
  assign accept        = bus.din_valid & din_ready_int;
  assign keep          = accept & (phase_q == '0);
  assign flush         = (state_q == SM_RUN) & ~enable;

  assign bus.din_ready  = din_ready_int;
  assign bus.dout_valid = ~fifo_empty;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    d_active_d = d_active_q;
    case (state_q)
      SM_IDLE: begin
        phase_d    = '0;
        d_active_d = factor_clamped;
        if (enable) state_d = SM_RUN;
      end
      SM_RUN: begin
        if (!enable) begin
          state_d = SM_IDLE;
          phase_d = '0;
        end else if (accept) begin
          // A new factor is only picked up at a group boundary.
          if (phase_q == d_active_q - CW'(1)) begin
            phase_d    = '0;
            d_active_d = factor_clamped;
          end else begin
            phase_d = phase_q + CW'(1);
          end
        end
      end
      default: state_d = SM_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SM_IDLE;
      phase_q    <= '0;
      d_active_q <= CW'(1);
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      d_active_q <= d_active_d;
    end
  end

  tiny_decimator_fifo #(
    .G_DATA_WIDTH (G_DATA_WIDTH),
    .G_DEPTH      (G_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_value   (bus.din),
    .wr_valid   (keep),
    .rd_accept  (bus.dout_ready),
    .flush      (flush),
    .head_value (bus.dout),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .level      (bus.fifo_level)
  );

`ifdef TINY_DECIMATOR_STATS_EN
  logic [31:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (state_q == SM_IDLE) begin
      drop_count_d = '0;
    end else if (accept && (phase_q != '0) && (drop_count_q != 32'hFFFF_FFFF)) begin
      drop_count_d = drop_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_count_q <= '0;
    else          drop_count_q <= drop_count_d;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_tiny_decimator.sv
// Scoreboard bench for tiny_decimator: directed groups push expected kept samples, a monitor pops on output handshakes.
module tb_tiny_decimator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  decim_factor = 5'd1;
`ifdef TINY_DECIMATOR_STATS_EN
  logic [31:0] drop_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_val;

  tiny_decimator_if #(.G_DATA_WIDTH(16), .G_FIFO_DEPTH(4)) bus();

  tiny_decimator #(
    .G_DATA_WIDTH (16),
    .G_MAX_DECIM  (16),
    .G_FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .decim_factor (decim_factor),
`ifdef TINY_DECIMATOR_STATS_EN
    .drop_count   (drop_count),
`endif
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every output handshake pops one expected sample.
  always @(negedge clk) begin
    if (reset_n && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected actual=%0h required=none", bus.dout);
      end else begin
        exp_val = exp_q.pop_front();
        check("dout", 32'(bus.dout), 32'(exp_val));
        $display("OUT dout=%0h expected=%0h", bus.dout, exp_val);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, output int waits);
    waits = 0;
    bus.din = v;
    bus.din_valid = 1'b1;
    @(negedge clk);
    while (!bus.din_ready && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 300) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=stalled required=accepted din=%0h", v);
    end
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
    $display("IN din=%0h waits=%0d", v, waits);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_empty_after"}, 32'(bus.dout_valid), 32'd0);
  endtask

  task automatic restart(input logic [4:0] f);
    step(1);
    enable = 1'b0;
    step(2);
    decim_factor = f;
    enable = 1'b1;
    step(2);
  endtask

  initial begin
    int w;
    int tot;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.dout_ready = 1'b0;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_din_ready", 32'(bus.din_ready), 32'd0);
    check("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    step(1);
    reset_n = 1'b1;

    // D=1: every sample kept, never stalled
    restart(5'd1);
    bus.dout_ready = 1'b1;
    tot = 0;
    for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
    for (int i = 1; i <= 8; i++) begin
      send(16'(i), w);
      tot += w;
    end
    check("t1_din_ready_waits", 32'(tot), 32'd0);
    drain("t1");

    // D=4: keep 0,4,8,12
    restart(5'd4);
    exp_q.push_back(16'd0); exp_q.push_back(16'd4);
    exp_q.push_back(16'd8); exp_q.push_back(16'd12);
    for (int i = 0; i < 16; i++) send(16'(i), w);
    drain("t2");
`ifdef TINY_DECIMATOR_STATS_EN
    check("t2_drop_count", drop_count, 32'd12);
`endif

    // D=2, output blocked: FIFO fills, only the next phase-0 sample stalls
    restart(5'd2);
    bus.dout_ready = 1'b0;
    exp_q.push_back(16'd0); exp_q.push_back(16'd2); exp_q.push_back(16'd4);
    exp_q.push_back(16'd6); exp_q.push_back(16'd8);
    tot = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(16'(i), w);
          if (i < 8) tot += w;
        end
      end
      begin
        int n = 0;
        @(negedge clk);
        while (!(bus.din_valid && bus.din == 16'd8) && n < 200) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        check("t3_level_full", 32'(bus.fifo_level), 32'd4);
        check("t3_din_ready_stall", 32'(bus.din_ready), 32'd0);
        check("t3_head", 32'(bus.dout), 32'd0);
        repeat (3) @(negedge clk);
        check("t3_level_stable", 32'(bus.fifo_level), 32'd4);
        check("t3_head_stable", 32'(bus.dout), 32'd0);
        check("t3_din_ready_held", 32'(bus.din_ready), 32'd0);
        @(posedge clk);
        #1;
        bus.dout_ready = 1'b1;
      end
    join
    check("t3_waits_before_8", 32'(tot), 32'd0);
    drain("t3");

    // D=3 then 5 mid-group: kept 0,3,8,13
    restart(5'd3);
    exp_q.push_back(16'd0); exp_q.push_back(16'd3);
    exp_q.push_back(16'd8); exp_q.push_back(16'd13);
    send(16'd0, w);
    send(16'd1, w);
    decim_factor = 5'd5;
    for (int i = 2; i < 14; i++) send(16'(i), w);
    drain("t4");

    // Factor 0 behaves as 1
    restart(5'd0);
    exp_q.push_back(16'h10); exp_q.push_back(16'h11); exp_q.push_back(16'h12);
    for (int i = 16; i < 19; i++) send(16'(i), w);
    drain("t5a");

    // Factor 31 clamps to 16
    restart(5'd31);
    exp_q.push_back(16'd100); exp_q.push_back(16'd116);
    for (int i = 100; i < 132; i++) send(16'(i), w);
    drain("t5b");

    // Mid-stream disable flushes the FIFO
    restart(5'd1);
    bus.dout_ready = 1'b0;
    send(16'hA0, w);
    send(16'hA1, w);
    @(negedge clk);
    check("t6_level_before", 32'(bus.fifo_level), 32'd2);
    check("t6_head_before", 32'(bus.dout), 32'hA0);
    step(1);
    enable = 1'b0;
    @(negedge clk);
    check("t6_valid_same_cycle", 32'(bus.dout_valid), 32'd1);
    @(negedge clk);
    check("t6_valid_after", 32'(bus.dout_valid), 32'd0);
    check("t6_level_after", 32'(bus.fifo_level), 32'd0);
    step(1);
    decim_factor = 5'd3;
    enable = 1'b1;
    step(2);
    bus.dout_ready = 1'b1;
    exp_q.push_back(16'h55);
    send(16'h55, w);
    send(16'h56, w);
    send(16'h57, w);
    drain("t6_reenable");

    // Asynchronous reset mid-stream
    bus.dout_ready = 1'b0;
    send(16'h77, w);
    send(16'h78, w);
    @(negedge clk);
    check("t6_level_pre_rst", 32'(bus.fifo_level), 32'd1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("arst_fifo_level", 32'(bus.fifo_level), 32'd0);
    check("arst_din_ready", 32'(bus.din_ready), 32'd0);
    check("arst_dout", 32'(bus.dout), 32'd0);
`ifdef TINY_DECIMATOR_STATS_EN
    check("arst_drop_count", drop_count, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
